// File: rtl/oflow_score_board.sv
// Score board: resolves each PE's candidate ID into a final object ID, one PE per cycle.
// Optional per-set statistics outputs are enabled by defining OFLOW_SCORE_BOARD_STATS_EN.
module oflow_score_board #(
    parameter int unsigned          PE_NUM    = 4,
    parameter int unsigned          ID_LEN    = 12,
    parameter int unsigned          SCORE_LEN = 16,
    parameter int unsigned          ROW_LEN   = 4,
    parameter logic [SCORE_LEN-1:0] SCORE_TH  = 16'h0400
) (
    input  logic                        clk,
    input  logic                        reset_N,
    input  logic                        start_score_board,
    input  logic                        first_frame,
    input  logic [ROW_LEN-1:0]          row_sel_by_set,
    input  logic [ID_LEN-1:0]           id_first_frame,
    input  logic [PE_NUM-1:0]           pe_valid,
    input  logic [PE_NUM*SCORE_LEN-1:0] pe_score,
    input  logic [PE_NUM*ID_LEN-1:0]    pe_cand_id,
    output logic                        done_score_board,
    output logic [PE_NUM*ID_LEN-1:0]    id_out,
    output logic [PE_NUM-1:0]           id_out_valid,
    output logic [ROW_LEN-1:0]          id_out_row,
    output logic                        id_overflow
`ifdef OFLOW_SCORE_BOARD_STATS_EN
    ,
    output logic [7:0]                  stat_matched,
    output logic [7:0]                  stat_new
`endif
);
    localparam int unsigned IDX_W = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 first_q, first_d;
    logic [ID_LEN-1:0]    base_q, base_d;
    logic [SCORE_LEN-1:0] score_q [PE_NUM];
    logic [SCORE_LEN-1:0] score_d [PE_NUM];
    logic [ID_LEN-1:0]    cand_q [PE_NUM];
    logic [ID_LEN-1:0]    cand_d [PE_NUM];
    logic [ID_LEN-1:0]    id_q [PE_NUM];
    logic [ID_LEN-1:0]    id_d [PE_NUM];
    logic [PE_NUM-1:0]    valid_q, valid_d;
    logic [ROW_LEN-1:0]   row_q, row_d;
    logic [PE_NUM-1:0]    clm_vld_q, clm_vld_d;
    logic [ID_LEN-1:0]    clm_id_q [PE_NUM];
    logic [ID_LEN-1:0]    clm_id_d [PE_NUM];
    logic [SCORE_LEN-1:0] clm_score_q [PE_NUM];
    logic [SCORE_LEN-1:0] clm_score_d [PE_NUM];
    logic [IDX_W-1:0]     clm_own_q [PE_NUM];
    logic [IDX_W-1:0]     clm_own_d [PE_NUM];
    logic [ID_LEN-1:0]    nid_q, nid_d;
    logic                 ovf_q, ovf_d;
`ifdef OFLOW_SCORE_BOARD_STATS_EN
    logic [7:0]           stm_q, stm_d;
    logic [7:0]           stn_q, stn_d;
`endif

    logic                 hit;
    logic [IDX_W-1:0]     hit_slot;
    logic                 alloc;
    logic                 new_claim;
    logic [ID_LEN-1:0]    cur_cand;
    logic [SCORE_LEN-1:0] cur_score;
    logic [ID_LEN-1:0]    ff_end;

    assign cur_cand  = cand_q[idx_q];
    assign cur_score = score_q[idx_q];

    // At most one claim entry can hold a given ID, so the last hit is the only hit.
    always_comb begin
        hit      = 1'b0;
        hit_slot = '0;
        for (int unsigned k = 0; k < PE_NUM; k++) begin
            if (clm_vld_q[k] && (clm_id_q[k] == cur_cand)) begin
                hit      = 1'b1;
                hit_slot = IDX_W'(k);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        first_d     = first_q;
        base_d      = base_q;
        score_d     = score_q;
        cand_d      = cand_q;
        id_d        = id_q;
        valid_d     = valid_q;
        row_d       = row_q;
        clm_vld_d   = clm_vld_q;
        clm_id_d    = clm_id_q;
        clm_score_d = clm_score_q;
        clm_own_d   = clm_own_q;
        nid_d       = nid_q;
        ovf_d       = ovf_q;
        alloc       = 1'b0;
        new_claim   = 1'b0;
        ff_end      = base_q + ID_LEN'(PE_NUM);
`ifdef OFLOW_SCORE_BOARD_STATS_EN
        stm_d       = stm_q;
        stn_d       = stn_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_score_board) begin
                    state_d = LOAD;
                    first_d = first_frame;
                    base_d  = id_first_frame;
                    valid_d = pe_valid;
                    row_d   = row_sel_by_set;
                    for (int unsigned k = 0; k < PE_NUM; k++) begin
                        score_d[k] = pe_score[k*SCORE_LEN +: SCORE_LEN];
                        cand_d[k]  = pe_cand_id[k*ID_LEN +: ID_LEN];
                    end
                end
            end
            LOAD: begin
                clm_vld_d = '0;
                idx_d     = '0;
                state_d   = SCAN;
`ifdef OFLOW_SCORE_BOARD_STATS_EN
                stm_d     = '0;
                stn_d     = '0;
`endif
            end
            SCAN: begin
                if (!valid_q[idx_q]) begin
                    id_d[idx_q] = '0;
                end else if (first_q) begin
                    id_d[idx_q] = base_q + ID_LEN'(idx_q);
                end else if (cur_score >= SCORE_TH) begin
                    id_d[idx_q] = nid_q;
                    alloc       = 1'b1;
                end else if (!hit) begin
                    id_d[idx_q]        = cur_cand;
                    new_claim          = 1'b1;
                    clm_vld_d[idx_q]   = 1'b1;
                    clm_id_d[idx_q]    = cur_cand;
                    clm_score_d[idx_q] = cur_score;
                    clm_own_d[idx_q]   = idx_q;
                end else if (cur_score < clm_score_q[hit_slot]) begin
                    // Strictly better score steals the ID; previous owner gets a fresh one.
                    id_d[idx_q]               = cur_cand;
                    id_d[clm_own_q[hit_slot]] = nid_q;
                    alloc                     = 1'b1;
                    clm_score_d[hit_slot]     = cur_score;
                    clm_own_d[hit_slot]       = idx_q;
                end else begin
                    id_d[idx_q] = nid_q;
                    alloc       = 1'b1;
                end
                if (alloc) begin
                    if (nid_q == '1) ovf_d = 1'b1;
                    else             nid_d = nid_q + ID_LEN'(1);
                end
`ifdef OFLOW_SCORE_BOARD_STATS_EN
                if (new_claim) stm_d = stm_q + 8'd1;
                if (alloc)     stn_d = stn_q + 8'd1;
`endif
                if (idx_q == IDX_W'(PE_NUM - 1)) state_d = DONE;
                else                             idx_d   = idx_q + IDX_W'(1);
            end
            DONE: begin
                if (first_q && (ff_end > nid_q)) nid_d = ff_end;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_N) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            first_q   <= 1'b0;
            base_q    <= '0;
            valid_q   <= '0;
            row_q     <= '0;
            clm_vld_q <= '0;
            nid_q     <= ID_LEN'(1);
            ovf_q     <= 1'b0;
            for (int unsigned k = 0; k < PE_NUM; k++) begin
                score_q[k]     <= '0;
                cand_q[k]      <= '0;
                id_q[k]        <= '0;
                clm_id_q[k]    <= '0;
                clm_score_q[k] <= '0;
                clm_own_q[k]   <= '0;
            end
`ifdef OFLOW_SCORE_BOARD_STATS_EN
            stm_q     <= '0;
            stn_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            first_q     <= first_d;
            base_q      <= base_d;
            valid_q     <= valid_d;
            row_q       <= row_d;
            clm_vld_q   <= clm_vld_d;
            nid_q       <= nid_d;
            ovf_q       <= ovf_d;
            score_q     <= score_d;
            cand_q      <= cand_d;
            id_q        <= id_d;
            clm_id_q    <= clm_id_d;
            clm_score_q <= clm_score_d;
            clm_own_q   <= clm_own_d;
`ifdef OFLOW_SCORE_BOARD_STATS_EN
            stm_q       <= stm_d;
            stn_q       <= stn_d;
`endif
        end
    end

    always_comb begin
        id_out = '0;
        for (int unsigned k = 0; k < PE_NUM; k++) begin
            id_out[k*ID_LEN +: ID_LEN] = id_q[k];
        end
    end

    assign done_score_board = (state_q == DONE);
    assign id_out_valid     = valid_q;
    assign id_out_row       = row_q;
    assign id_overflow      = ovf_q;
`ifdef OFLOW_SCORE_BOARD_STATS_EN
    assign stat_matched     = stm_q;
    assign stat_new         = stn_q;
`endif

endmodule

// File: tb/tb_oflow_score_board.sv
// Self-checking bench for oflow_score_board: directed vector table, hand-written corner
// sequences, then randomized sets against a queue/associative-array reference model.
module tb_oflow_score_board;
    typedef struct {
        logic        first;
        logic [3:0]  row;
        logic [11:0] base;
        logic [3:0]  valid;
        logic [63:0] score;
        logic [47:0] cand;
        logic [47:0] exp_id;
        logic        exp_ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_N;
    logic        start;
    logic        first_frame;
    logic [3:0]  row_sel;
    logic [11:0] id_ff;
    logic [3:0]  pe_valid;
    logic [63:0] pe_score;
    logic [47:0] pe_cand;
    logic        done;
    logic [47:0] id_out;
    logic [3:0]  id_out_valid;
    logic [3:0]  id_out_row;
    logic        id_overflow;
`ifdef OFLOW_SCORE_BOARD_STATS_EN
    logic [7:0]  stat_matched;
    logic [7:0]  stat_new;
`endif

    oflow_score_board #(
        .PE_NUM(4), .ID_LEN(12), .SCORE_LEN(16), .ROW_LEN(4), .SCORE_TH(16'h0400)
    ) dut (
        .clk(clk), .reset_N(reset_N), .start_score_board(start),
        .first_frame(first_frame), .row_sel_by_set(row_sel), .id_first_frame(id_ff),
        .pe_valid(pe_valid), .pe_score(pe_score), .pe_cand_id(pe_cand),
        .done_score_board(done), .id_out(id_out), .id_out_valid(id_out_valid),
        .id_out_row(id_out_row), .id_overflow(id_overflow)
`ifdef OFLOW_SCORE_BOARD_STATS_EN
        , .stat_matched(stat_matched), .stat_new(stat_new)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_nid;
    bit m_ovf;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] pk_id(input int a0, input int a1, input int a2, input int a3);
        return {12'(a3), 12'(a2), 12'(a1), 12'(a0)};
    endfunction

    function automatic logic [63:0] pk_sc(input int a0, input int a1, input int a2, input int a3);
        return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    function automatic vec_t mk(input logic f, input int row, input int base, input logic [3:0] vld,
                                input logic [63:0] sc, input logic [47:0] cd,
                                input logic [47:0] ex, input logic ov);
        vec_t v;
        v.first = f; v.row = 4'(row); v.base = 12'(base); v.valid = vld;
        v.score = sc; v.cand = cd; v.exp_id = ex; v.exp_ovf = ov;
        return v;
    endfunction

    function automatic int m_alloc();
        int v = m_nid;
        if (m_nid == 4095) m_ovf = 1'b1;
        else               m_nid++;
        return v;
    endfunction

    // Reference: walk PEs in order, tracking which PE currently owns each claimed ID.
    task automatic model_set(input vec_t v, output logic [47:0] ids_o);
        int owner[int];
        int ids[4];
        int c, j;
        for (int i = 0; i < 4; i++) begin
            c = int'(v.cand[i*12 +: 12]);
            if (!v.valid[i])                          ids[i] = 0;
            else if (v.first)                         ids[i] = (int'(v.base) + i) % 4096;
            else if (v.score[i*16 +: 16] >= 16'h0400) ids[i] = m_alloc();
            else if (!owner.exists(c)) begin
                ids[i] = c; owner[c] = i;
            end else begin
                j = owner[c];
                if (v.score[i*16 +: 16] < v.score[j*16 +: 16]) begin
                    ids[i] = c; owner[c] = i; ids[j] = m_alloc();
                end else begin
                    ids[i] = m_alloc();
                end
            end
        end
        if (v.first && ((int'(v.base) + 4) % 4096) > m_nid) m_nid = (int'(v.base) + 4) % 4096;
        ids_o = pk_id(ids[0], ids[1], ids[2], ids[3]);
    endtask

    task automatic drive(input vec_t v);
        first_frame = v.first; row_sel = v.row; id_ff = v.base;
        pe_valid = v.valid; pe_score = v.score; pe_cand = v.cand;
    endtask

    task automatic run_set(input string name, input vec_t v, input bit busy);
        int   cyc;
        int   extra;
        vec_t alt;
        alt = v;
        alt.cand = ~v.cand; alt.valid = ~v.valid; alt.row = v.row + 4'd1; alt.first = ~v.first;
        @(negedge clk);
        drive(v);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (busy && cyc == 2) begin
                drive(alt);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({name, " latency"}, 64'(cyc), 64'd6);
        check({name, " id_out"}, 64'(id_out), 64'(v.exp_id));
        check({name, " id_out_valid"}, 64'(id_out_valid), 64'(v.valid));
        check({name, " id_out_row"}, 64'(id_out_row), 64'(v.row));
        check({name, " id_overflow"}, 64'(id_overflow), 64'(v.exp_ovf));
        @(negedge clk);
        check({name, " done width"}, 64'(done), 64'd0);
        if (busy) begin
            extra = 0;
            repeat (12) begin
                @(negedge clk);
                if (done === 1'b1) extra++;
            end
            check({name, " extra done"}, 64'(extra), 64'd0);
            check({name, " id_out held"}, 64'(id_out), 64'(v.exp_id));
        end
    endtask

    vec_t tbl[11];
    vec_t v;
    int   seen;

    initial begin
        reset_N = 1'b1; start = 1'b0; first_frame = 1'b0; row_sel = '0; id_ff = '0;
        pe_valid = '0; pe_score = '0; pe_cand = '0;
        repeat (3) @(negedge clk);
        check("reset done", 64'(done), 64'd0);
        check("reset id_out", 64'(id_out), 64'd0);
        check("reset valid", 64'(id_out_valid), 64'd0);
        check("reset row", 64'(id_out_row), 64'd0);
        check("reset ovf", 64'(id_overflow), 64'd0);
        reset_N = 1'b0;

        tbl[0]  = mk(1, 1, 9, 4'b1111, pk_sc(0, 0, 0, 0), pk_id(0, 0, 0, 0), pk_id(9, 10, 11, 12), 0);
        tbl[1]  = mk(0, 2, 0, 4'b1111, pk_sc('h10, 'h10, 'h10, 'h10), pk_id(3, 5, 7, 2), pk_id(3, 5, 7, 2), 0);
        tbl[2]  = mk(1, 3, 16, 4'b1111, pk_sc(0, 0, 0, 0), pk_id(0, 0, 0, 0), pk_id(16, 17, 18, 19), 0);
        tbl[3]  = mk(0, 4, 0, 4'b1111, pk_sc('h100, 'h10, 'h50, 'h10), pk_id(5, 8, 5, 9), pk_id(20, 8, 5, 9), 0);
        tbl[4]  = mk(0, 5, 0, 4'b1111, pk_sc('h400, 'h80, 'h3ff, 'h80), pk_id(6, 4, 10, 4), pk_id(21, 4, 10, 22), 0);
        tbl[5]  = mk(0, 6, 0, 4'b0101, pk_sc('h10, 'hffff, 'h20, 'h10), pk_id(3, 3, 3, 7), pk_id(3, 0, 23, 0), 0);
        tbl[6]  = mk(1, 7, 100, 4'b1011, pk_sc(0, 0, 0, 0), pk_id(0, 0, 0, 0), pk_id(100, 101, 0, 103), 0);
        tbl[7]  = mk(0, 8, 0, 4'b1111, pk_sc('h500, 'h500, 'h500, 'h500), pk_id(1, 2, 3, 4), pk_id(104, 105, 106, 107), 0);
        tbl[8]  = mk(1, 9, 4091, 4'b1111, pk_sc(0, 0, 0, 0), pk_id(0, 0, 0, 0), pk_id(4091, 4092, 4093, 4094), 0);
        tbl[9]  = mk(0, 10, 0, 4'b0011, pk_sc('h800, 'h800, 0, 0), pk_id(1, 1, 0, 0), pk_id(4095, 4095, 0, 0), 1);
        tbl[10] = mk(1, 11, 4094, 4'b1111, pk_sc(0, 0, 0, 0), pk_id(0, 0, 0, 0), pk_id(4094, 4095, 0, 1), 1);
        for (int i = 0; i < 11; i++) run_set($sformatf("vec%0d", i), tbl[i], 1'b0);

        // Second start two cycles into a busy set must be dropped.
        v = mk(0, 12, 0, 4'b1111, pk_sc('h10, 'h20, 'h30, 'h40), pk_id(1, 2, 3, 4), pk_id(1, 2, 3, 4), 1);
        run_set("busy", v, 1'b1);

        // Reset while scanning: no done pulse, everything back to reset values.
        v = mk(0, 13, 0, 4'b1111, pk_sc('h800, 'h800, 'h800, 'h800), pk_id(1, 2, 3, 4), '0, 0);
        @(negedge clk);
        drive(v);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset_N = 1'b1;
        @(negedge clk);
        reset_N = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("midreset done", 64'(seen), 64'd0);
        check("midreset id_out", 64'(id_out), 64'd0);
        check("midreset valid", 64'(id_out_valid), 64'd0);
        check("midreset row", 64'(id_out_row), 64'd0);
        check("midreset ovf", 64'(id_overflow), 64'd0);

        m_nid = 1;
        m_ovf = 1'b0;
        v = mk(0, 14, 0, 4'b0001, pk_sc('hffff, 0, 0, 0), pk_id(7, 0, 0, 0), pk_id(1, 0, 0, 0), 0);
        run_set("post reset alloc", v, 1'b0);
        model_set(v, v.exp_id);

        for (int n = 0; n < 40; n++) begin
            v.first = ($urandom_range(0, 7) == 0);
            v.row   = 4'($urandom);
            v.base  = 12'($urandom_range(0, 3000));
            v.valid = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(0, 3))
                    0:       v.score[i*16 +: 16] = 16'h0080;
                    1:       v.score[i*16 +: 16] = 16'h03ff;
                    2:       v.score[i*16 +: 16] = 16'h0400;
                    default: v.score[i*16 +: 16] = 16'($urandom_range(0, 'h800));
                endcase
                v.cand[i*12 +: 12] = 12'($urandom_range(1, 5));
            end
            model_set(v, v.exp_id);
            v.exp_ovf = m_ovf;
            run_set($sformatf("rnd%0d", n), v, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/oflow_score_board.md
Name: oflow_score_board

Overview:
- Consumes one set of PE results per `start_score_board` pulse from the registration FSM.
- Inputs per PE: best score and candidate previous-frame ID from score calc.
- Resolves each PE to a final object ID: match, conflict resolution, or new-ID allocation.
- Reports completion with a one-cycle `done_score_board` pulse and drives the per-PE ID table row selected by `row_sel_by_set`.

Parameters:
- PE_NUM, 4, PEs per set
- ID_LEN, 12, object ID width
- SCORE_LEN, 16, score width (unsigned, lower is better)
- ROW_LEN, 4, row-select width
- SCORE_TH, 16'h0400, match threshold; score must be strictly below it to match

Ports:
- clk  in  1  clock
- reset_N  in  1  reset; one clock; reset is synchronous and active-high
- start_score_board  in  1  one-cycle start pulse
- first_frame  in  1  1 = current frame is frame 0
- row_sel_by_set  in  ROW_LEN  table row for this set
- id_first_frame  in  ID_LEN  base ID of this set on the first frame
- pe_valid  in  PE_NUM  per-PE object present
- pe_score  in  PE_NUM*SCORE_LEN  flattened, PE0 at LSBs
- pe_cand_id  in  PE_NUM*ID_LEN  flattened candidate previous IDs
- done_score_board  out  1  one-cycle done pulse
- id_out  out  PE_NUM*ID_LEN  resolved IDs, stable from done until next start
- id_out_valid  out  PE_NUM  per-PE valid, copy of captured pe_valid
- id_out_row  out  ROW_LEN  captured row_sel_by_set
- id_overflow  out  1  sticky, new-ID space exhausted

Behaviour:
- Reset values:
  - done_score_board, id_out, id_out_valid, id_out_row, id_overflow = 0.
  - FSM = IDLE.
  - Internal next_new_id = 1.
- FSM states: IDLE -> LOAD -> SCAN -> DONE -> IDLE.
- IDLE: on start_score_board go to LOAD.
- LOAD: capture all inputs into registers.
  - Clear the per-set claim table (PE_NUM entries: claimed flag, id, score, owner PE).
  - Scan index i = 0.
- SCAN: one PE per cycle, i = 0..PE_NUM-1; go to DONE after i = PE_NUM-1.
  - Invalid PE: id_out[i] = 0, no allocation.
  - first_frame = 1: id_out[i] = id_first_frame + i, no claim check.
  - first_frame = 0 and score >= SCORE_TH: id_out[i] = next_new_id; next_new_id++.
  - Score < SCORE_TH and cand_id unclaimed: id_out[i] = cand_id; record claim.
  - Cand_id claimed by PE j with score_i < score_j:
    - i takes cand_id; claim owner becomes i.
    - id_out[j] = next_new_id; next_new_id++.
  - Cand_id claimed and score_i >= score_j (tie goes to the earlier PE): id_out[i] = next_new_id; next_new_id++.
- DONE:
  - done_score_board = 1 for exactly one cycle.
  - On the first frame: next_new_id = max(next_new_id, id_first_frame + PE_NUM).
  - Return to IDLE.
- Latency: start at cycle T -> done at T + PE_NUM + 2.
- start_score_board outside IDLE is ignored. No queueing.
- Allocation at next_new_id = 2^ID_LEN-1:
  - That value is issued.
  - Counter saturates.
  - id_overflow set; it clears only on reset.
  - Any later allocation reissues the same value.
- Reset mid-operation: abort to IDLE, all outputs to reset values, no done pulse.
- Width rule: id_first_frame + i is computed modulo 2^ID_LEN; no overflow flag for first-frame IDs.

Optional Feature:
- Macro: OFLOW_SCORE_BOARD_STATS_EN.
- Enabled: adds outputs stat_matched (8 bit) and stat_new (8 bit).
  - Per-set counts of matched and newly allocated IDs.
  - Valid on the done cycle; held until next LOAD.
  - A displaced PE counts as new; its earlier match count is decremented.
- Disabled: ports and logic absent; all other behaviour identical.

Test Plan:
1. First frame: first_frame = 1, id_first_frame = 9, pe_valid = 4'b1111 -> id_out = {12,11,10,9}; done exactly 6 cycles after start; next_new_id = 13.
2. Clean match: first_frame = 0, cands {3,5,7,2}, all scores 16'h0010 -> id_out = {2,7,5,3}; no allocation.
3. Conflict, later PE wins: PE0 cand 5 score 0x0100, PE2 cand 5 score 0x0050, next_new_id = 20 -> PE2 = 5, PE0 = 20, next_new_id = 21.
4. Tie and threshold:
   - PE1/PE3 cand 4, both score 0x0080 -> PE1 = 4, PE3 = new.
   - PE0 score 0x0400 -> new ID regardless of its candidate.
5. Overflow and reset:
   - next_new_id = 4095 with two allocations -> both get 4095; id_overflow = 1.
   - Reset during SCAN -> no done pulse; outputs = 0.
6. Start ignored while busy: second start pulse 2 cycles after the first -> exactly one done; results reflect only the first set.
